// File: rtl/scpu_mem_arbiter_pkg.sv
// Shared types and helpers for the scpu memory arbiter.
// Holds the arbiter state encoding and the starvation-counter width helper.
// Imported by the arbiter top and its starvation counter.
package scpu_mem_arbiter_pkg;

    // Arbiter ownership of the single memory port.
    typedef enum logic [1:0] {
        SCPU_ARB_IDLE   = 2'd0,
        SCPU_ARB_BUSY_I = 2'd1,
        SCPU_ARB_BUSY_D = 2'd2
    } arb_state_t;

    // Counter width able to hold 0..limit inclusive.
    function automatic int starve_cnt_w(input int limit);
        int w;
        w = $clog2(limit + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/scpu_mem_arbiter_starve_ctr.sv
// Counts back-to-back data grants taken while fetch is waiting; raises force_fetch at the limit.
// Latency: force_fetch reflects the count registered on the previous edge.
// Backpressure: none; it only observes grants and the fetch request level.
module scpu_arb_starve_ctr
    import scpu_mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_idle,
    input  logic i_fetch_req,
    input  logic i_fetch_gnt,
    input  logic i_data_gnt,
    output logic o_force_fetch
);

    localparam int              CNT_W = starve_cnt_w(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] r_cnt;

    // Fetch grants and idle cycles without a fetch request wipe the streak;
    // data grants that overtake a waiting fetch extend it, saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_fetch_gnt) begin
            r_cnt <= '0;
        end else if (i_data_gnt && i_fetch_req) begin
            if (r_cnt != LIMIT) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (i_idle && !i_fetch_req) begin
            r_cnt <= '0;
        end
    end

    assign o_force_fetch = (r_cnt == LIMIT);

endmodule

// File: rtl/scpu_mem_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store, data first with a starvation guard.
// Latency: grant in cycle 0, mem_req from cycle 1, ack in cycle k gives rvalid in cycle k+1 (minimum 2).
// Backpressure: one transaction in flight; grants are withheld while busy and mem_req holds until mem_ack.
module scpu_mem_arbiter
    import scpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    // instruction fetch side
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_adr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    // load/store side
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_adr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    // memory side
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_adr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic                mem_ack,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;

    // Request captured at grant time; drives the memory port for the whole transaction.
    logic              r_lat_we;
    logic [ADDR_W-1:0] r_lat_adr;
    logic [DATA_W-1:0] r_lat_wdata;
    logic [BE_W-1:0]   r_lat_be;

    logic              r_i_rvalid;
    logic              r_d_rvalid;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic              w_idle;
    logic              w_force_fetch;
    logic              w_d_win;
    logic              w_i_win;
    logic              w_ack_i;
    logic              w_ack_d;

    assign w_idle  = (r_state == SCPU_ARB_IDLE);

    // Data wins unless fetch is waiting and has already been passed over STARVE_LIMIT times.
    assign w_d_win = w_idle && d_req && !(i_req && w_force_fetch);
    assign w_i_win = w_idle && i_req && !w_d_win;

    // Acks only count while a transaction is outstanding; stray acks in IDLE fall through.
    assign w_ack_i = (r_state == SCPU_ARB_BUSY_I) && mem_ack;
    assign w_ack_d = (r_state == SCPU_ARB_BUSY_D) && mem_ack;

    scpu_arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk           (clk),
        .reset         (reset),
        .i_idle        (w_idle),
        .i_fetch_req   (i_req),
        .i_fetch_gnt   (w_i_win),
        .i_data_gnt    (w_d_win),
        .o_force_fetch (w_force_fetch)
    );

    // State register; reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= SCPU_ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: a grant opens a transaction, mem_ack closes it.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            SCPU_ARB_IDLE: begin
                if (w_d_win) begin
                    w_state_nxt = SCPU_ARB_BUSY_D;
                end else if (w_i_win) begin
                    w_state_nxt = SCPU_ARB_BUSY_I;
                end
            end
            SCPU_ARB_BUSY_I,
            SCPU_ARB_BUSY_D: begin
                if (mem_ack) begin
                    w_state_nxt = SCPU_ARB_IDLE;
                end
            end
            default: begin
                w_state_nxt = SCPU_ARB_IDLE;
            end
        endcase
    end

    // Outputs: grants only in IDLE, memory port driven from the latch only while busy.
    always_comb begin
        i_gnt     = w_i_win;
        d_gnt     = w_d_win;
        busy      = !w_idle;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (!w_idle) begin
            mem_req   = 1'b1;
            mem_we    = r_lat_we;
            mem_adr   = r_lat_adr;
            mem_wdata = r_lat_wdata;
            mem_be    = r_lat_be;
        end
    end

    // Capture the winner's request at the grant edge; fetches are full-word reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lat_we    <= 1'b0;
            r_lat_adr   <= '0;
            r_lat_wdata <= '0;
            r_lat_be    <= '0;
        end else if (w_d_win) begin
            r_lat_we    <= d_we;
            r_lat_adr   <= d_adr;
            r_lat_wdata <= d_wdata;
            r_lat_be    <= d_be;
        end else if (w_i_win) begin
            r_lat_we    <= 1'b0;
            r_lat_adr   <= i_adr;
            r_lat_wdata <= '0;
            r_lat_be    <= '1;
        end
    end

    // Register read data on ack and pulse rvalid the following cycle; rdata holds until the next pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_i_rdata  <= '0;
            r_d_rdata  <= '0;
        end else begin
            r_i_rvalid <= w_ack_i;
            r_d_rvalid <= w_ack_d;
            if (w_ack_i) begin
                r_i_rdata <= mem_rdata;
            end
            // Stores also capture the bus; consumers ignore d_rdata after a store.
            if (w_ack_d) begin
                r_d_rdata <= mem_rdata;
            end
        end
    end

    assign i_rvalid = r_i_rvalid;
    assign i_rdata  = r_i_rdata;
    assign d_rvalid = r_d_rvalid;
    assign d_rdata  = r_d_rdata;

endmodule

// File: tb/tb_scpu_mem_arbiter.sv
module tb_scpu_mem_arbiter;

    localparam int LIM = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_adr;
    logic        i_gnt, i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req, d_we;
    logic [31:0] d_adr, d_wdata;
    logic [3:0]  d_be;
    logic        d_gnt, d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_adr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        busy;

    always #5 clk = ~clk;

    scpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIM)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_adr(i_adr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: who owns the memory, how long until it answers, and
    // how many times a waiting fetch has been overtaken by data.
    int          m_owner;          // 0 none, 1 fetch, 2 data
    int          m_wait;
    int          m_streak;
    logic        m_we;
    logic [31:0] m_adr, m_wdata;
    logic [3:0]  m_be;
    logic        m_irv, m_drv;
    logic [31:0] m_irdata, m_drdata;
    bit          m_drd_known;
    logic [31:0] mem_arr [logic [31:0]];

    int  next_lat;
    bit  spur_ack;
    bit  log_en;
    int  glog[$];                  // 1 = data grant, 2 = fetch grant
    bit  last_ig, last_dg;
    bit  s_ig, s_drv;
    int  obs_busy, obs_irv, obs_drv;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] k;
        k = {a[31:2], 2'b00};
        if (mem_arr.exists(k)) return mem_arr[k];
        return {~k[15:0], k[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic mem_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic [31:0] w;
        w = mem_read(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
        mem_arr[{a[31:2], 2'b00}] = w;
    endtask

    // One clock cycle: entered at posedge+1 with requests already driven.
    task automatic do_cycle();
        logic        e_dg, e_ig, ack;
        logic [31:0] rd;
        e_dg = (m_owner == 0) && d_req && !(i_req && m_streak >= LIM);
        e_ig = (m_owner == 0) && i_req && !e_dg;
        ack  = (m_owner != 0) ? (m_wait == 0) : spur_ack;
        rd   = (m_owner != 0 && !m_we) ? mem_read(m_adr) : $urandom();
        mem_ack   = ack;
        mem_rdata = rd;
        #1;
        chk("i_gnt", i_gnt, e_ig);
        chk("d_gnt", d_gnt, e_dg);
        chk("mem_req", mem_req, m_owner != 0);
        chk("busy", busy, m_owner != 0);
        chk("i_rvalid", i_rvalid, m_irv);
        chk("d_rvalid", d_rvalid, m_drv);
        chk("i_rdata", i_rdata, m_irdata);
        if (m_drd_known) chk("d_rdata", d_rdata, m_drdata);
        if (m_owner != 0) begin
            chk("mem_adr", mem_adr, m_adr);
            chk("mem_we", mem_we, m_we);
            chk("mem_be", mem_be, m_be);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        s_ig  = i_gnt;
        s_drv = d_rvalid;
        if (mem_req)  obs_busy++;
        if (i_rvalid) obs_irv++;
        if (d_rvalid) obs_drv++;
        if (log_en) begin
            if (d_gnt) glog.push_back(1);
            if (i_gnt) glog.push_back(2);
        end
        @(posedge clk);
        if (reset) begin
            m_owner = 0; m_streak = 0; m_irv = 0; m_drv = 0;
            m_irdata = '0; m_drdata = '0; m_drd_known = 1;
            last_ig = 0; last_dg = 0;
        end else begin
            m_irv = 0; m_drv = 0;
            last_ig = e_ig; last_dg = e_dg;
            if (m_owner != 0) begin
                if (ack) begin
                    if (m_owner == 1) begin
                        m_irv = 1; m_irdata = rd;
                    end else begin
                        m_drv = 1;
                        if (m_we) begin
                            mem_write(m_adr, m_wdata, m_be); m_drd_known = 0;
                        end else begin
                            m_drdata = rd; m_drd_known = 1;
                        end
                    end
                    m_owner = 0;
                end else begin
                    m_wait--;
                end
            end else begin
                if (e_ig) m_streak = 0;
                else if (e_dg && i_req) m_streak = (m_streak >= LIM) ? LIM : m_streak + 1;
                else if (!i_req) m_streak = 0;
                if (e_dg) begin
                    m_owner = 2; m_we = d_we; m_adr = d_adr; m_wdata = d_wdata; m_be = d_be;
                    m_wait = next_lat;
                end else if (e_ig) begin
                    m_owner = 1; m_we = 0; m_adr = i_adr; m_be = 4'hF;
                    m_wait = next_lat;
                end
            end
        end
        #1;
    endtask

    task automatic idle_cycles(input int n);
        i_req = 0; d_req = 0;
        repeat (n) do_cycle();
    endtask

    function automatic logic [31:0] rnd_adr();
        return 32'h100 + ($urandom_range(0, 7) << 2);
    endfunction

    initial begin
        int k, ig_cyc, drv_cyc;
        bit hit;
        reset = 1; i_req = 0; i_adr = '0; d_req = 0; d_we = 0; d_adr = '0;
        d_wdata = '0; d_be = '0; mem_ack = 0; mem_rdata = '0;
        m_owner = 0; m_wait = 0; m_streak = 0; m_we = 0; m_adr = '0; m_wdata = '0; m_be = '0;
        m_irv = 0; m_drv = 0; m_irdata = '0; m_drdata = '0; m_drd_known = 1;
        next_lat = 0; spur_ack = 0; log_en = 0; last_ig = 0; last_dg = 0;
        obs_busy = 0; obs_irv = 0; obs_drv = 0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_d_rdata", d_rdata, 0);
        do_cycle();
        reset = 0;
        do_cycle();

        // Fetch only, ack one cycle after mem_req
        next_lat = 0; i_req = 1; i_adr = 32'h10;
        do_cycle();
        i_req = 0;
        chk("t1_mem_req_c1", mem_req, 1);
        chk("t1_mem_adr_c1", mem_adr, 32'h10);
        do_cycle();
        chk("t1_i_rvalid_c2", i_rvalid, 1);
        chk("t1_i_rdata_c2", i_rdata, mem_read(32'h10));
        do_cycle();
        idle_cycles(2);

        // Both request with an empty streak: data first, fetch in the cycle data returns
        next_lat = 1;
        i_req = 1; i_adr = 32'h14;
        d_req = 1; d_we = 0; d_adr = 32'h20; d_be = 4'hF;
        #1;
        chk("t2_d_gnt", d_gnt, 1);
        chk("t2_i_gnt", i_gnt, 0);
        do_cycle();
        d_req = 0;
        ig_cyc = -1; drv_cyc = -1;
        for (int c = 1; c <= 8 && ig_cyc < 0; c++) begin
            do_cycle();
            if (s_drv) drv_cyc = c;
            if (s_ig) ig_cyc = c;
        end
        i_req = 0;
        chk("t2_d_rvalid_cycle", drv_cyc, 3);
        chk("t2_i_gnt_cycle", ig_cyc, 3);
        idle_cycles(6);

        // Both held continuously: D,D,D,D,I repeating
        glog.delete(); log_en = 1;
        i_req = 1; i_adr = 32'h30; d_req = 1; d_we = 0; d_adr = 32'h34; d_be = 4'hF;
        k = 0;
        while (glog.size() < 10 && k < 200) begin
            next_lat = $urandom_range(0, 2);
            do_cycle();
            k++;
        end
        log_en = 0;
        chk("t3_grant_count", glog.size() >= 10, 1);
        for (int n = 0; n < 10 && n < glog.size(); n++)
            chk($sformatf("t3_grant_%0d", n), glog[n], ((n % (LIM + 1)) == LIM) ? 2 : 1);
        idle_cycles(8);

        // Delayed store: five busy cycles, one d_rvalid, no i_rvalid
        next_lat = 4;
        d_req = 1; d_we = 1; d_adr = 32'h40; d_wdata = 32'hCAFE_BABE; d_be = 4'b0011;
        obs_busy = 0; obs_irv = 0; obs_drv = 0;
        do_cycle();
        d_req = 0; d_we = 0;
        repeat (8) do_cycle();
        chk("t4_busy_cycles", obs_busy, 5);
        chk("t4_d_rvalid_pulses", obs_drv, 1);
        chk("t4_i_rvalid_pulses", obs_irv, 0);
        next_lat = 0;
        d_req = 1; d_adr = 32'h40; d_be = 4'hF;
        do_cycle();
        d_req = 0;
        idle_cycles(3);

        // Reset mid BUSY_D while memory acks; the streak must be cleared too
        next_lat = 0;
        i_req = 1; i_adr = 32'h50; d_req = 1; d_we = 0; d_adr = 32'h54;
        hit = 0;
        for (int c = 0; c < 50 && !hit; c++) begin
            if (m_owner == 2 && m_wait == 0 && m_streak >= 2) hit = 1;
            else do_cycle();
        end
        chk("t5_reached_busy_d", hit, 1);
        reset = 1; i_req = 0; d_req = 0;
        do_cycle();
        reset = 0;
        chk("t5_mem_req", mem_req, 0);
        chk("t5_busy", busy, 0);
        chk("t5_no_d_rvalid", d_rvalid, 0);
        do_cycle();
        glog.delete(); log_en = 1;
        i_req = 1; d_req = 1;
        k = 0;
        while (glog.size() < 5 && k < 60) begin
            do_cycle();
            k++;
        end
        log_en = 0;
        chk("t5_grant_count", glog.size() >= 5, 1);
        for (int n = 0; n < 5 && n < glog.size(); n++)
            chk($sformatf("t5_grant_%0d", n), glog[n], (n == LIM) ? 2 : 1);
        idle_cycles(4);

        // Spurious ack in IDLE
        spur_ack = 1;
        do_cycle();
        spur_ack = 0;
        chk("t6_i_rvalid", i_rvalid, 0);
        chk("t6_d_rvalid", d_rvalid, 0);
        chk("t6_busy", busy, 0);
        do_cycle();

        // Random traffic against the model
        for (int c = 0; c < 800; c++) begin
            if (last_ig) begin
                i_req = $urandom_range(0, 1); i_adr = rnd_adr();
            end else if (i_req && $urandom_range(0, 15) == 0) begin
                i_req = 0;
            end else if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req = 1; i_adr = rnd_adr();
            end
            if (last_dg || (!d_req && $urandom_range(0, 2) == 0)) begin
                d_req = last_dg ? 1'($urandom_range(0, 1)) : 1'b1;
                d_we = $urandom_range(0, 1); d_adr = rnd_adr();
                d_wdata = $urandom(); d_be = $urandom_range(1, 15);
            end else if (d_req && $urandom_range(0, 15) == 0) begin
                d_req = 0;
            end
            next_lat = $urandom_range(0, 3);
            spur_ack = ($urandom_range(0, 7) == 0);
            do_cycle();
        end
        spur_ack = 0;
        idle_cycles(6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
